// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, the pending-write record and default sizing for the MIPS32 writeback path.
package mips32_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int DATA_W          = 32;
    localparam int WB_DEPTH        = 4;
    localparam int WB_STARVE_LIMIT = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] regno;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_FIFO
    } wb_sel_e;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of ALU/MDU result inputs, register-file write port and forwarding query for the arbiter.
interface writeback_arbiter_if;
    import mips32_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0]     alu_data;
    logic                  mdu_valid;
    logic [REG_ADDR_W-1:0] mdu_reg;
    logic [DATA_W-1:0]     mdu_data;
    logic                  mdu_ready;
    logic                  alu_stall;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0]     WriteData;
    logic [REG_ADDR_W-1:0] byp_reg;
    logic                  byp_hit;
    logic [DATA_W-1:0]     byp_data;

    modport master (
        output alu_valid, alu_reg, alu_data, mdu_valid, mdu_reg, mdu_data, byp_reg,
        input  mdu_ready, alu_stall, RegWrite, WriteReg, WriteData, byp_hit, byp_data
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mdu_valid, mdu_reg, mdu_data, byp_reg,
        output mdu_ready, alu_stall, RegWrite, WriteReg, WriteData, byp_hit, byp_data
    );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// In-order queue of pending MDU results; also exposes every slot ordered oldest-first
// so the parent can search pending writes without knowing the pointer layout.
module wb_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  wb_entry_t                      i_push_entry,
    output wb_entry_t                      o_head,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic [DEPTH-1:0]               o_age_valid,
    output wb_entry_t [DEPTH-1:0]          o_age_entry
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset: slots only become visible through the count.
    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wptr] <= i_push_entry;
    end

    always_comb begin
        o_age_valid = '0;
        o_age_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_age_entry[i] = r_mem[r_rptr + PTR_W'(i)];
            o_age_valid[i] = (CNT_W'(i) < r_count);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU results win the register-file port, MDU results queue in wb_fifo,
// and a starve counter forces the queue head through. WRITEBACK_BYPASS_EN adds a pending-write search.
module writeback_arbiter
    import mips32_pkg::*;
#(
    parameter int DEPTH        = WB_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic               clock,
    input  logic               reset_n,
    writeback_arbiter_if.slave bus
);
    localparam int         CNT_W      = $clog2(DEPTH + 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [CNT_W-1:0]      w_count;
    logic [DEPTH-1:0]      w_age_valid;
    wb_entry_t [DEPTH-1:0] w_age_entry;
    wb_entry_t             w_head;
    wb_entry_t             w_push_entry;
    wb_entry_t             w_sel_entry;
    wb_sel_e               w_sel;
    logic                  w_fifo_nempty;
    logic                  w_mdu_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_alu_ok;
    logic [3:0]            r_starve;
    logic [3:0]            w_starve_nxt;
    logic                  r_alu_stall;
    logic                  w_stall_nxt;
    logic                  r_wr_en_p1;
    logic [REG_ADDR_W-1:0] r_wr_reg_p1;
    logic [DATA_W-1:0]     r_wr_data_p1;

    assign w_fifo_nempty = (w_count != '0);
    assign w_mdu_ready   = (w_count < CNT_W'(DEPTH));
    // Writes to $zero are accepted on the handshake but never queued.
    assign w_push        = bus.mdu_valid && w_mdu_ready && (bus.mdu_reg != '0);
    assign w_alu_ok      = bus.alu_valid && (bus.alu_reg != '0) && !r_alu_stall;
    assign w_push_entry  = '{regno: bus.mdu_reg, data: bus.mdu_data};
    assign w_pop         = (w_sel == SEL_FIFO);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_push_entry (w_push_entry),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_age_valid  (w_age_valid),
        .o_age_entry  (w_age_entry)
    );

    // Stage p0: choose the source for this cycle's write.
    always_comb begin
        w_sel       = SEL_NONE;
        w_sel_entry = '0;
        if (r_alu_stall && w_fifo_nempty) begin
            w_sel       = SEL_FIFO;
            w_sel_entry = w_head;
        end else if (w_alu_ok) begin
            w_sel       = SEL_ALU;
            w_sel_entry = '{regno: bus.alu_reg, data: bus.alu_data};
        end else if (w_fifo_nempty) begin
            w_sel       = SEL_FIFO;
            w_sel_entry = w_head;
        end
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_pop || !w_fifo_nempty) begin
            w_starve_nxt = '0;
        end else if ((w_sel == SEL_ALU) && (r_starve < STARVE_MAX)) begin
            w_starve_nxt = r_starve + 4'd1;
        end
    end

    // Only the transition onto the limit raises the stall, so a saturated counter pulses once.
    assign w_stall_nxt = (w_starve_nxt == STARVE_MAX) && (r_starve != STARVE_MAX);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_starve    <= '0;
            r_alu_stall <= 1'b0;
        end else begin
            r_starve    <= w_starve_nxt;
            r_alu_stall <= w_stall_nxt;
        end
    end

    // Stage p1: registered register-file write port; address/data hold when idle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_en_p1   <= 1'b0;
            r_wr_reg_p1  <= '0;
            r_wr_data_p1 <= '0;
        end else begin
            r_wr_en_p1 <= (w_sel != SEL_NONE);
            if (w_sel != SEL_NONE) begin
                r_wr_reg_p1  <= w_sel_entry.regno;
                r_wr_data_p1 <= w_sel_entry.data;
            end
        end
    end

    assign bus.mdu_ready = w_mdu_ready;
    assign bus.alu_stall = r_alu_stall;
    assign bus.RegWrite  = r_wr_en_p1;
    assign bus.WriteReg  = r_wr_reg_p1;
    assign bus.WriteData = r_wr_data_p1;

`ifdef WRITEBACK_BYPASS_EN
    logic              w_byp_hit;
    logic [DATA_W-1:0] w_byp_data;

    // Later (younger) matches overwrite earlier ones; the output register is oldest of all.
    always_comb begin
        w_byp_hit  = 1'b0;
        w_byp_data = '0;
        if (bus.byp_reg != '0) begin
            if (r_wr_en_p1 && (r_wr_reg_p1 == bus.byp_reg)) begin
                w_byp_hit  = 1'b1;
                w_byp_data = r_wr_data_p1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_age_valid[i] && (w_age_entry[i].regno == bus.byp_reg)) begin
                    w_byp_hit  = 1'b1;
                    w_byp_data = w_age_entry[i].data;
                end
            end
        end
    end

    assign bus.byp_hit  = w_byp_hit;
    assign bus.byp_data = w_byp_data;
`else
    logic w_unused_byp;
    assign w_unused_byp = ^{bus.byp_reg, w_age_valid, w_age_entry};
    assign bus.byp_hit  = 1'b0;
    assign bus.byp_data = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes go into a queue, a negedge monitor checks them.
module tb_writeback_arbiter;
    import mips32_pkg::*;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    wb_entry_t exp_q[$];
    wb_entry_t mon_e;

    writeback_arbiter_if bus ();

    writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.RegWrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got write reg %0d data 0x%0h, required no write",
                         bus.WriteReg, bus.WriteData);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.WriteReg !== mon_e.regno || bus.WriteData !== mon_e.data) begin
                    errors++;
                    $display("FAIL sb_write: got reg %0d data 0x%0h, required reg %0d data 0x%0h",
                             bus.WriteReg, bus.WriteData, mon_e.regno, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                          input logic mv, input logic [4:0] mr, input logic [31:0] md);
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
        bus.mdu_valid = mv;
        bus.mdu_reg   = mr;
        bus.mdu_data  = md;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wb_entry_t t;
        t.regno = r;
        t.data  = d;
        exp_q.push_back(t);
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        bus.byp_reg = 5'd0;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset state
        tick();
        tick();
        chk("rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("rst_writereg", {27'd0, bus.WriteReg}, 32'd0);
        chk("rst_writedata", bus.WriteData, 32'd0);
        chk("rst_alu_stall", {31'd0, bus.alu_stall}, 32'd0);
        chk("rst_byp_hit", {31'd0, bus.byp_hit}, 32'd0);
        chk("rst_byp_data", bus.byp_data, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_mdu_ready", {31'd0, bus.mdu_ready}, 32'd1);

        // Single ALU write, then address/data hold while idle
        set_in(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd5, 32'h1234);
        tick();
        idle(1);
        chk("alu_hold_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("alu_hold_writereg", {27'd0, bus.WriteReg}, 32'd5);
        chk("alu_hold_writedata", bus.WriteData, 32'h1234);
        idle(1);
        chk("alu_q_empty", exp_q.size(), 32'd0);

        // Four MDU results with idle ALU drain in order
        for (int c = 0; c < 4; c++) begin
            set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + c), 32'h100 + c);
            chk("mdu_ready_idle_alu", {31'd0, bus.mdu_ready}, 32'd1);
            expect_wr(5'(8 + c), 32'h100 + c);
            tick();
        end
        idle(3);
        chk("mdu_q_empty", exp_q.size(), 32'd0);

        // Fill the FIFO under continuous ALU traffic until the starve stall forces the head out
        for (int c = 0; c <= 9; c++) begin
            if (c < 4) set_in(1'b1, 5'(c + 1), 32'hA000 + c, 1'b1, 5'(16 + c), 32'hB000 + c);
            else if (c < 9) set_in(1'b1, 5'(c + 1), 32'hA000 + c, 1'b1, 5'd20, 32'hB004);
            else set_in(1'b1, 5'd30, 32'hDEAD, 1'b1, 5'd20, 32'hB004);
            chk("starve_mdu_ready", {31'd0, bus.mdu_ready}, (c < 4) ? 32'd1 : 32'd0);
            chk("starve_alu_stall", {31'd0, bus.alu_stall}, (c == 9) ? 32'd1 : 32'd0);
            if (c < 9) expect_wr(5'(c + 1), 32'hA000 + c);
            else expect_wr(5'd16, 32'hB000);
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("starve_stall_drop", {31'd0, bus.alu_stall}, 32'd0);
        chk("starve_ready_back", {31'd0, bus.mdu_ready}, 32'd1);
        for (int c = 1; c < 4; c++) expect_wr(5'(16 + c), 32'hB000 + c);
        idle(6);
        chk("starve_q_empty", exp_q.size(), 32'd0);

        // Writes to register 0 are dropped on both sources
        set_in(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hAAAA);
        chk("r0_mdu_ready", {31'd0, bus.mdu_ready}, 32'd1);
        tick();
        idle(1);
        chk("r0_fifo_count", 32'(dut.u_fifo.o_count), 32'd0);
        idle(2);
        chk("r0_q_empty", exp_q.size(), 32'd0);

        // Pending reg-7 entries, forwarding query, then reset mid-operation
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h11);
        expect_wr(5'd3, 32'h33);
        tick();
        set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'h22);
        expect_wr(5'd4, 32'h44);
        tick();
        set_in(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd5, 32'h55);
        bus.byp_reg = 5'd7;
        #1;
`ifdef WRITEBACK_BYPASS_EN
        chk("byp_fifo_hit", {31'd0, bus.byp_hit}, 32'd1);
        chk("byp_fifo_data", bus.byp_data, 32'h22);
        bus.byp_reg = 5'd4;
        #1;
        chk("byp_outreg_hit", {31'd0, bus.byp_hit}, 32'd1);
        chk("byp_outreg_data", bus.byp_data, 32'h44);
        bus.byp_reg = 5'd0;
        #1;
        chk("byp_r0_hit", {31'd0, bus.byp_hit}, 32'd0);
`else
        chk("byp_tied_hit", {31'd0, bus.byp_hit}, 32'd0);
        chk("byp_tied_data", bus.byp_data, 32'd0);
`endif
        chk("midrst_count_before", 32'(dut.u_fifo.o_count), 32'd2);
        tick();
        reset_n = 1'b0;
        set_in(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        tick();
        reset_n = 1'b1;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.byp_reg = 5'd7;
        #1;
        chk("midrst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("midrst_writereg", {27'd0, bus.WriteReg}, 32'd0);
        chk("midrst_writedata", bus.WriteData, 32'd0);
        chk("midrst_mdu_ready", {31'd0, bus.mdu_ready}, 32'd1);
        chk("midrst_count", 32'(dut.u_fifo.o_count), 32'd0);
        chk("midrst_byp_hit", {31'd0, bus.byp_hit}, 32'd0);
        chk("midrst_byp_data", bus.byp_data, 32'd0);
        idle(4);
        chk("midrst_q_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001: Parameter DEPTH, default 4; number of entries in the MDU result FIFO (power of two, 2..16).
REQ-002: Parameter STARVE_LIMIT, default 8; number of consecutive cycles the FIFO head may wait before it is forced to the write port.
REQ-003: clock  input  1  single clock; all state updates on the rising edge.
REQ-004: reset_n  input  1  synchronous reset, active-low, sampled on the rising edge of clock.
REQ-005: alu_valid  input  1  ALU result present this cycle; no ready signal.
REQ-006: alu_reg  input  5  ALU destination register number.
REQ-007: alu_data  input  32  ALU result value.
REQ-008: mdu_valid  input  1  multiply/divide result offered.
REQ-009: mdu_reg  input  5  MDU destination register number.
REQ-010: mdu_data  input  32  MDU result value.
REQ-011: mdu_ready  output  1  FIFO can accept an MDU result this cycle.
REQ-012: alu_stall  output  1  upstream holds its ALU result; alu_valid is ignored this cycle.
REQ-013: RegWrite  output  1  register file write enable.
REQ-014: WriteReg  output  5  register file write address.
REQ-015: WriteData  output  32  register file write data.
REQ-016: byp_reg  input  5  forwarding query register number (WB_BYPASS_EN only).
REQ-017: byp_hit  output  1  a pending FIFO entry targets byp_reg.
REQ-018: byp_data  output  32  data of the newest matching pending entry.

Function
REQ-019: An MDU transfer SHALL occur when mdu_valid and mdu_ready are both high; mdu_ready SHALL be high when the registered FIFO count is less than DEPTH.
- A pop in the same cycle does not free a slot.
REQ-020: An accepted MDU result with mdu_reg==0 SHALL be discarded and not pushed.
REQ-021: An ALU result with alu_reg==0 SHALL be treated as alu_valid low.
REQ-022: Per-cycle selection SHALL be:
- if alu_stall is high and the FIFO is non-empty: pop the FIFO;
- else if alu_valid is high (and alu_reg!=0): take the ALU result;
- else if the FIFO is non-empty: pop the FIFO;
- else: no write.
REQ-023: RegWrite, WriteReg and WriteData SHALL be registered; the selected write SHALL appear exactly one cycle after selection and last one cycle.
REQ-024: RegWrite SHALL be low in any cycle after which nothing was selected; WriteReg and WriteData SHALL then hold their previous values.
REQ-025: A 4-bit starve counter SHALL behave as follows:
- increment each cycle the FIFO is non-empty and the ALU wins;
- clear on any FIFO pop or when the FIFO is empty;
- saturate at STARVE_LIMIT.
REQ-026: alu_stall SHALL be registered and high for exactly the one cycle following the cycle in which the counter reaches STARVE_LIMIT.
REQ-027: Ordering between ALU and MDU writes to the same register is the scheduler's responsibility; the FIFO SHALL preserve MDU order.
REQ-028: FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-029: While reset_n is low at a clock edge, the following SHALL be forced low/zero: FIFO count and pointers, starve counter, RegWrite, alu_stall, WriteReg, WriteData, byp_hit and byp_data.
REQ-030: mdu_ready SHALL be high from the first cycle after reset is released.
REQ-031: Any write selected in the cycle reset asserts SHALL be lost.
REQ-032: FIFO contents SHALL be discarded on reset mid-operation.

Configuration
REQ-033: With macro WRITEBACK_BYPASS_EN defined:
- byp_hit SHALL be combinational, high when any valid FIFO entry, or the registered output with RegWrite high, has reg==byp_reg!=0;
- byp_data SHALL come from the youngest match, with priority order FIFO tail-most entry > output register.
REQ-034: Without WRITEBACK_BYPASS_EN, byp_hit and byp_data SHALL be tied to zero and byp_reg SHALL be unused.

Structure
REQ-035: Package mips32_pkg SHALL hold:
- REG_ADDR_W=5 and DATA_W=32;
- typedef wb_entry_t {reg, data};
- DEPTH and STARVE_LIMIT defaults.
REQ-036: The FIFO SHALL be sub-module wb_fifo, with push/pop/count ports and a per-entry read-out for the bypass search.

Verification
REQ-037: ALU only: alu_valid=1, alu_reg=5, alu_data=0x1234 in cycle N -> RegWrite=1, WriteReg=5, WriteData=0x1234 in cycle N+1 only.
REQ-038: Idle ALU, four MDU pushes (regs 8..11) -> four writes in push order on consecutive cycles.
- mdu_ready remains high throughout (DEPTH=4).
REQ-039: FIFO full with continuous ALU traffic -> mdu_ready=0.
- alu_stall pulses once after 8 ALU wins;
- the next cycle writes the FIFO head;
- an ALU value offered during the stall is not written.
REQ-040: Writes to register 0 from ALU (0xFFFF) and MDU (0xAAAA) -> no RegWrite; FIFO count unchanged.
REQ-041: WRITEBACK_BYPASS_EN: FIFO holds reg 7 with values 0x11 then 0x22, byp_reg=7 -> byp_hit=1, byp_data=0x22.
- reset_n low for one cycle -> byp_hit=0, count=0.
